// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the frame-memory address helper.
package vga_timing_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int H_FRONT    = 16;
    localparam int H_SYNC_W   = 96;
    localparam int H_BACK     = 48;
    localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;

    localparam int V_VISIBLE  = 480;
    localparam int V_FRONT    = 10;
    localparam int V_SYNC_W   = 2;
    localparam int V_BACK     = 33;
    localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;

    localparam int SCALE_DEF  = 4;
    localparam int VIRT_W_DEF = 160;

    // Row times a constant row pitch, built from shifted copies of the row.
    // With a constant k this reduces to a handful of adders (160 = 128 + 32).
    function automatic logic [14:0] shift_add_mul(input logic [9:0] v, input logic [14:0] k);
        logic [14:0] acc;
        acc = '0;
        for (int i = 0; i < 15; i++) begin
            if (k[i]) acc = acc + (15'(v) << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel tick, x/y raster counters, raw active-low syncs and end-of-frame pulse.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_VISIBLE,
    parameter int H_FP     = H_FRONT,
    parameter int H_SYNC   = H_SYNC_W,
    parameter int H_BP     = H_BACK,
    parameter int V_ACTIVE = V_VISIBLE,
    parameter int V_FP     = V_FRONT,
    parameter int V_SYNC   = V_SYNC_W,
    parameter int V_BP     = V_BACK
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       tick_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       active_o,
    output logic       frame_done_o
);

    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       phase_q, phase_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       fd_q, fd_d;

    // Next raster position; counters only move on the tick phase.
    always_comb begin
        phase_d = ~phase_q;
        x_d     = x_q;
        y_d     = y_q;
        fd_d    = 1'b0;
        if (phase_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fd_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Raster state registers; phase starts at 0 so the first tick lands on the second clk.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fd_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fd_q    <= fd_d;
        end
    end

    assign tick_o       = phase_q;
    assign x_o          = x_q;
    assign y_o          = y_q;
    assign frame_done_o = fd_q;
    assign active_o     = (x_q < H_ACT) && (y_q < V_ACT);
    assign hsync_n_o    = !((x_q >= HS_BEG) && (x_q < HS_END));
    assign vsync_n_o    = !((y_q >= VS_BEG) && (y_q < VS_END));

endmodule

// File: rtl/frame_scanout_reader.sv
// Scans a 160x120 frame memory out to VGA, each word replicated over a 4x4 block.
// Read issued the clk after the tick that samples a position; RGB and delayed
// syncs/blank update together one tick later.
module frame_scanout_reader
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_VISIBLE,
    parameter int V_ACTIVE    = V_VISIBLE,
    parameter int PIXEL_SCALE = SCALE_DEF,
    parameter int VIRT_WIDTH  = VIRT_W_DEF,
    parameter int H_FP        = H_FRONT,
    parameter int H_SYNC      = H_SYNC_W,
    parameter int H_BP        = H_TOTAL - H_VISIBLE - H_FRONT - H_SYNC_W,
    parameter int V_FP        = V_FRONT,
    parameter int V_SYNC      = V_SYNC_W,
    parameter int V_BP        = V_TOTAL - V_VISIBLE - V_FRONT - V_SYNC_W
) (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] mem_rd_addr,
    output logic        mem_rd_en,
    input  logic [23:0] mem_rd_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        active_pixels,
    output logic        frame_done
);

    localparam int          SCALE_SH   = $clog2(PIXEL_SCALE);
    localparam int          MEM_WORDS  = VIRT_WIDTH * (V_ACTIVE / PIXEL_SCALE);
    localparam logic [14:0] ADDR_LIMIT = 15'(MEM_WORDS);
    localparam logic [14:0] ROW_PITCH  = 15'(VIRT_WIDTH);

    logic        tick;
    logic        hsync_raw, vsync_raw;
    logic [9:0]  col, row;
    logic [14:0] addr_calc;
    logic        issue;

    logic [14:0] addr_q, addr_d;
    logic        rd_en_q, rd_en_d;
    logic        vis_q, vis_d;
    logic        hs_p_q, hs_p_d;
    logic        vs_p_q, vs_p_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_o       (tick),
        .x_o          (x),
        .y_o          (y),
        .hsync_n_o    (hsync_raw),
        .vsync_n_o    (vsync_raw),
        .active_o     (active_pixels),
        .frame_done_o (frame_done)
    );

    assign col       = x >> SCALE_SH;
    assign row       = y >> SCALE_SH;
    assign addr_calc = shift_add_mul(row, ROW_PITCH) + 15'(col);
    // The limit guard keeps a mis-sized raster from ever reading past the frame buffer.
    assign issue     = active_pixels && (addr_calc < ADDR_LIMIT);

    // Two-stage pixel pipeline: stage 1 issues the read and carries syncs,
    // stage 2 lands RGB together with the delayed syncs and blank.
    always_comb begin
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        vis_d   = vis_q;
        hs_p_d  = hs_p_q;
        vs_p_d  = vs_p_q;
        rgb_d   = rgb_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        if (tick) begin
            rd_en_d = issue;
            if (issue) addr_d = addr_calc;
            vis_d   = issue;
            hs_p_d  = hsync_raw;
            vs_p_d  = vsync_raw;
            rgb_d   = vis_q ? mem_rd_data : '0;
            hs_d    = hs_p_q;
            vs_d    = vs_p_q;
            blank_d = vis_q;
        end
    end

    // Pipeline registers; clearing vis_q on reset drops any read still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            vis_q   <= 1'b0;
            hs_p_q  <= 1'b1;
            vs_p_q  <= 1'b1;
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            vis_q   <= vis_d;
            hs_p_q  <= hs_p_d;
            vs_p_q  <= vs_p_d;
            rgb_q   <= rgb_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
        end
    end

    assign mem_rd_addr = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = tick;

endmodule

// File: doc/frame_scanout_reader.md
FRAME_SCANOUT_READER -- requirements
Module: frame_scanout_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter PIXEL_SCALE, default 4, meaning screen pixels per memory word along each axis (160x120 virtual grid).
REQ-004 SHALL have parameter VIRT_WIDTH, default 160, meaning memory words per virtual row.
REQ-005 SHALL provide the following ports (one clock; reset is asynchronous and active-high):
  clk  input  1  50 MHz system clock.
  rst  input  1  asynchronous active-high reset.
  mem_rd_addr  output  15  frame-memory read address.
  mem_rd_en  output  1  read strobe.
  mem_rd_data  input  24  RGB word; valid exactly 1 clk after mem_rd_en.
  VGA_R, VGA_G, VGA_B  output  8 each  pixel colour.
  VGA_HS, VGA_VS  output  1  syncs, active low.
  VGA_BLANK_N  output  1  high during visible pixels.
  VGA_SYNC_N  output  1  tied 0.
  VGA_CLK  output  1  25 MHz pixel clock (toggles every clk).
  x, y  output  10 each  current counter position.
  active_pixels  output  1  counter position is visible.
  frame_done  output  1  one-clk pulse at end of frame.

Function
REQ-006 SHALL generate a pixel tick every second clk; all counter/output updates occur only on ticks.
REQ-007 SHALL count x 0..799 and y 0..524; x wraps to 0 and y increments at x=799; y wraps to 0 at (x=799, y=524).
REQ-008 SHALL assert active_pixels when x<640 and y<480.
REQ-009 SHALL drive raw hsync low for x in 656..751 and raw vsync low for y in 490..491.
REQ-010 SHALL compute mem_rd_addr = (y/4)*160 + (x/4) using shifts and shift-add only (no multiplier), 15-bit result, range 0..19199.
REQ-011 SHALL assert mem_rd_en for one clk, the clk following each tick, only when active_pixels; mem_rd_addr holds otherwise.
REQ-012 SHALL capture mem_rd_data into VGA_R/G/B (bits 23:16, 15:8, 7:0) on the next tick, and drive 0 on RGB when the pipelined position is not visible.
REQ-013 SHALL delay VGA_HS, VGA_VS and VGA_BLANK_N by exactly one pixel tick so they align with RGB; total latency counter->RGB = 1 pixel period (2 clk).
REQ-014 SHALL pulse frame_done for one clk on the tick where (x,y) wraps to (0,0).
REQ-015 SHALL never issue an address >=19200; out-of-range mem_rd_data is never captured.

Reset
REQ-016 SHALL, while rst=1, hold x=0, y=0, tick phase=0, mem_rd_addr=0, mem_rd_en=0, RGB=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_CLK=0, frame_done=0.
REQ-017 SHALL, on rst asserted mid-frame, abandon the frame immediately and, after release, restart at (0,0) with first tick on the second clk.
REQ-018 SHALL discard any read in flight when reset asserts; no stale data reaches RGB after release.

Structure
REQ-019 SHALL take H/V timing constants (active, front porch, sync, back porch, totals) and PIXEL_SCALE from shared package vga_timing_pkg.
REQ-020 SHALL instantiate one sub-module vga_timing_gen (tick, x/y counters, raw syncs, active, frame_done); address generation and output pipeline stay in the top.

Verification
REQ-021 Release reset -> first mem_rd_en with addr 0 at clk 2; RGB equals returned data 2 clk after counter reached (0,0).
REQ-022 Drive counter to x=4,y=0 -> addr 1; x=0,y=4 -> addr 160; x=639,y=479 -> addr 19199.
REQ-023 Run one line -> VGA_HS low for exactly 96 ticks starting 1 tick after x=656; VGA_BLANK_N high 640 ticks.
REQ-024 Run one frame -> VGA_VS low for 2 lines (1600 ticks); frame_done pulses once every 840000 clk.
REQ-025 Memory model returns 24'hFF0000 everywhere -> RGB=FF/00/00 in visible region, 0 during blanking.
REQ-026 Assert rst at x=300,y=200 -> all outputs at reset values within same cycle; after release, sequence restarts per REQ-021.
